dcache_mem_bridge: RTL and testbench
====================================

Name: dcache_mem_bridge

Overview:
- Memory-side controller for the data cache's line-refill and write-back port.
- On a miss it writes back the dirty victim line, if any, as a burst of narrow beats. It then fetches the missing line as a burst, assembles it into one SET_WIDTH block and presents it with a one-cycle block-write strobe.
- Sits between the dcache (victim line/address out, refill block in) and the external memory bus, using valid/ready handshakes on every channel.

Parameters:
- SET_WIDTH, 512, cache line width in bits.
- BUS_WIDTH, 64, memory data beat width; SET_WIDTH must be an integer multiple.
- ADDR_WIDTH, 64, byte address width.
- (derived) BEATS = SET_WIDTH/BUS_WIDTH = 8; LINE_OFF = $clog2(SET_WIDTH/8) = 6.

Ports:
- i_clk  in  1  clock.
- i_arstn  in  1  asynchronous active-low reset.
- i_miss  in  1  start request, sampled in IDLE only.
- i_dirty  in  1  victim line is dirty, sampled with i_miss.
- i_addr  in  ADDR_WIDTH  miss address.
- i_addr_wb  in  ADDR_WIDTH  victim write-back address.
- i_wb_block  in  SET_WIDTH  victim line data.
- o_block  out  SET_WIDTH  assembled refill line.
- o_block_we  out  1  one-cycle refill strobe to the cache.
- o_busy  out  1  high in any state except IDLE.
- o_mem_avalid  out  1  address request valid.
- i_mem_aready  in  1  address accepted.
- o_mem_addr  out  ADDR_WIDTH  line-aligned burst address.
- o_mem_we  out  1  1 = write burst, 0 = read burst.
- o_mem_wvalid  out  1  write beat valid.
- i_mem_wready  in  1  write beat accepted.
- o_mem_wdata  out  BUS_WIDTH  write beat.
- o_mem_wlast  out  1  final write beat.
- i_mem_bvalid  in  1  write response.
- o_mem_bready  out  1  ready for write response.
- i_mem_rvalid  in  1  read beat valid.
- o_mem_rready  out  1  ready for read beat.
- i_mem_rdata  in  BUS_WIDTH  read beat.
- i_mem_rlast  in  1  final read beat flag.
- o_err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
Reset:
- Asynchronous, active low. State = IDLE; beat counter = 0; o_block = 0.
- All valid, ready and strobe outputs = 0; o_busy = 0; o_err = 0.
- Reset mid-burst abandons the transaction; there is no resume.

States: IDLE, WB_ADDR, WB_DATA, WB_RESP, RD_ADDR, RD_DATA, DONE.

IDLE:
- On i_miss=1, capture i_addr, i_addr_wb and i_wb_block into internal registers.
- Go to WB_ADDR if i_dirty=1, otherwise RD_ADDR.
- After capture, changes on the inputs have no effect.

WB_ADDR:
- o_mem_avalid=1, o_mem_we=1, o_mem_addr = captured wb address with bits [LINE_OFF-1:0] forced to 0.
- Go to WB_DATA on avalid&aready.

WB_DATA:
- o_mem_wvalid=1; o_mem_wdata = beat[cnt], where beat k = line bits [(k+1)*BUS_WIDTH-1 : k*BUS_WIDTH], beat 0 first.
- o_mem_wlast = (cnt == BEATS-1).
- cnt increments only on wvalid&wready.
- Accepting the last beat clears cnt and moves to WB_RESP.
- wdata holds stable while wready=0.

WB_RESP:
- o_mem_bready=1; go to RD_ADDR on bvalid.

RD_ADDR:
- o_mem_avalid=1, o_mem_we=0, o_mem_addr = captured miss address, line-aligned.
- Go to RD_DATA on handshake.

RD_DATA:
- o_mem_rready=1.
- Each rvalid&rready writes i_mem_rdata into o_block slice cnt, then increments cnt.
- After beat BEATS-1, cnt returns to 0 and the state moves to DONE.

DONE:
- o_block_we=1 for exactly one cycle with o_block complete and stable; next state IDLE.
- o_block holds its value until the next refill begins overwriting it.

Handshake rules:
- A valid, once asserted, is not dropped before its handshake completes, and its payload does not change.
- Zero-wait-state memory (ready/valid tied high): clean refill = 1 (RD_ADDR) + 8 (beats) + 1 (DONE) = 10 cycles from i_miss to o_block_we; dirty refill adds 1 + 8 + 1 = 10 more.
- An i_miss asserted while busy is ignored; the cache holds i_miss until o_block_we.

Optional Feature:
- Macro: DCACHE_BRIDGE_RLAST_CHECK_EN.
- Defined: in RD_DATA, the bridge compares i_mem_rlast on every accepted beat against (cnt == BEATS-1). Any mismatch, either early or missing, sets o_err, which stays 1 until reset. Data flow and the beat count are unchanged: exactly BEATS beats are always consumed.
- Not defined: i_mem_rlast is ignored and o_err is tied to 0.

Test Plan:
- Clean miss, zero-wait memory, i_addr=0x1234 -> o_mem_addr=0x1200, o_mem_we=0; beats 0x0..0x7 give o_block={0x7,...,0x0}; o_block_we pulses one cycle, 10 cycles after i_miss.
- Dirty miss, i_addr_wb=0x8040, i_wb_block beats 0xA0..0xA7 -> write burst to 0x8040 with wdata 0xA0..0xA7 in order and wlast only on 0xA7; the read burst starts only after bvalid.
- Random wready/rvalid stalls (50%) -> wdata and avalid stay stable under stall; exactly 8 beats per direction; final o_block matches the zero-wait case.
- i_miss re-pulsed during RD_DATA, plus i_arstn low mid-WB_DATA -> the second miss is ignored; reset returns all outputs to 0 and state to IDLE immediately, and a new i_miss then works normally.
- With DCACHE_BRIDGE_RLAST_CHECK_EN defined, rlast on beat 5 -> o_err=1 and sticky, 8 beats still consumed; without the macro, the same stimulus leaves o_err=0.

Source files
------------

// File: rtl/dcache_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_mem_bridge
//  Purpose  : Memory-side refill / write-back controller for the data cache.
//             On a miss it optionally writes the dirty victim line out as a
//             burst of BUS_WIDTH beats, then reads the missing line as a
//             burst, assembles it into one SET_WIDTH block and presents it
//             with a one-cycle block-write strobe.
//
//  Ports    : i_clk / i_arstn          clock, asynchronous active-low reset
//             i_miss, i_dirty          refill request and victim-dirty flag
//             i_addr, i_addr_wb        miss address, victim address
//             i_wb_block               victim line data
//             o_block, o_block_we      assembled refill line + strobe
//             o_busy                   controller not idle
//             o_mem_a*                 burst address channel (valid/ready)
//             o_mem_w*                 write beat channel (valid/ready/last)
//             i_mem_bvalid/o_mem_bready write response channel
//             i_mem_r*/o_mem_rready    read beat channel (valid/ready/last)
//             o_err                    sticky read-burst framing error
//
//  Options  : DCACHE_BRIDGE_RLAST_CHECK_EN -- when defined, every accepted
//             read beat's i_mem_rlast is checked against the beat position
//             and any disagreement sets the sticky o_err. When undefined,
//             i_mem_rlast is ignored and o_err is tied low.
//
//  Revision : 1.0  initial release
// ============================================================================
module dcache_mem_bridge #(
    parameter int SET_WIDTH  = 512,
    parameter int BUS_WIDTH  = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arstn,

    input  logic                  i_miss,
    input  logic                  i_dirty,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ADDR_WIDTH-1:0] i_addr_wb,
    input  logic [SET_WIDTH-1:0]  i_wb_block,
    output logic [SET_WIDTH-1:0]  o_block,
    output logic                  o_block_we,
    output logic                  o_busy,

    output logic                  o_mem_avalid,
    input  logic                  i_mem_aready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_we,

    output logic                  o_mem_wvalid,
    input  logic                  i_mem_wready,
    output logic [BUS_WIDTH-1:0]  o_mem_wdata,
    output logic                  o_mem_wlast,

    input  logic                  i_mem_bvalid,
    output logic                  o_mem_bready,

    input  logic                  i_mem_rvalid,
    output logic                  o_mem_rready,
    input  logic [BUS_WIDTH-1:0]  i_mem_rdata,
    input  logic                  i_mem_rlast,

    output logic                  o_err
);

    // SET_WIDTH is expected to be an integer multiple of BUS_WIDTH.
    localparam int c_beats    = SET_WIDTH / BUS_WIDTH;
    localparam int c_line_off = $clog2(SET_WIDTH / 8);
    localparam int c_cnt_w    = (c_beats > 1) ? $clog2(c_beats) : 1;
    localparam int c_tag_w    = ADDR_WIDTH - c_line_off;

    localparam logic [c_cnt_w-1:0] c_last_beat = c_cnt_w'(c_beats - 1);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_wb_addr = 3'd1;
    localparam logic [2:0] c_st_wb_data = 3'd2;
    localparam logic [2:0] c_st_wb_resp = 3'd3;
    localparam logic [2:0] c_st_rd_addr = 3'd4;
    localparam logic [2:0] c_st_rd_data = 3'd5;
    localparam logic [2:0] c_st_done    = 3'd6;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]           state_q,    state_d;
    logic [c_cnt_w-1:0]   cnt_q,      cnt_d;
    // Only the line-number part of each address is kept; the offset bits
    // are always driven as zero on the bus.
    logic [c_tag_w-1:0]   addr_q,     addr_d;
    logic [c_tag_w-1:0]   addr_wb_q,  addr_wb_d;
    logic [SET_WIDTH-1:0] wb_block_q, wb_block_d;
    logic [SET_WIDTH-1:0] block_q,    block_d;

    logic                 w_last_beat;

    assign w_last_beat = (cnt_q == c_last_beat);

`ifdef DCACHE_BRIDGE_RLAST_CHECK_EN
    logic err_q, err_d;
`else
    logic w_unused_rlast;
    assign w_unused_rlast = i_mem_rlast;
`endif

    // Offset bits of the incoming addresses are intentionally discarded.
    logic w_unused_offsets;
    assign w_unused_offsets = &{1'b0, i_addr[c_line_off-1:0], i_addr_wb[c_line_off-1:0]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        addr_wb_d  = addr_wb_q;
        wb_block_d = wb_block_q;
        block_d    = block_q;
`ifdef DCACHE_BRIDGE_RLAST_CHECK_EN
        err_d      = err_q;
`endif

        case (state_q)
            c_st_idle: begin
                if (i_miss) begin
                    addr_d     = i_addr[ADDR_WIDTH-1:c_line_off];
                    addr_wb_d  = i_addr_wb[ADDR_WIDTH-1:c_line_off];
                    wb_block_d = i_wb_block;
                    state_d    = i_dirty ? c_st_wb_addr : c_st_rd_addr;
                end
            end

            c_st_wb_addr: begin
                if (i_mem_aready) begin
                    state_d = c_st_wb_data;
                end
            end

            c_st_wb_data: begin
                if (i_mem_wready) begin
                    if (w_last_beat) begin
                        cnt_d   = '0;
                        state_d = c_st_wb_resp;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            c_st_wb_resp: begin
                if (i_mem_bvalid) begin
                    state_d = c_st_rd_addr;
                end
            end

            c_st_rd_addr: begin
                if (i_mem_aready) begin
                    state_d = c_st_rd_data;
                end
            end

            c_st_rd_data: begin
                if (i_mem_rvalid) begin
                    block_d[int'(cnt_q)*BUS_WIDTH +: BUS_WIDTH] = i_mem_rdata;
`ifdef DCACHE_BRIDGE_RLAST_CHECK_EN
                    // Early or missing rlast is flagged but never shortens
                    // or lengthens the burst: exactly c_beats are consumed.
                    if (i_mem_rlast != w_last_beat) begin
                        err_d = 1'b1;
                    end
`endif
                    if (w_last_beat) begin
                        cnt_d   = '0;
                        state_d = c_st_done;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            c_st_done: begin
                state_d = c_st_idle;
            end

            default: begin
                state_d = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state_q    <= c_st_idle;
            cnt_q      <= '0;
            addr_q     <= '0;
            addr_wb_q  <= '0;
            wb_block_q <= '0;
            block_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            addr_wb_q  <= addr_wb_d;
            wb_block_q <= wb_block_d;
            block_q    <= block_d;
        end
    end

`ifdef DCACHE_BRIDGE_RLAST_CHECK_EN
    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state, so every payload is
    // held stable for as long as its valid stays high.
    // ------------------------------------------------------------------
    assign o_busy       = (state_q != c_st_idle);
    assign o_mem_avalid = (state_q == c_st_wb_addr) || (state_q == c_st_rd_addr);
    assign o_mem_we     = (state_q == c_st_wb_addr);
    assign o_mem_addr   = (state_q == c_st_wb_addr) ? {addr_wb_q, {c_line_off{1'b0}}}
                                                    : {addr_q,    {c_line_off{1'b0}}};
    assign o_mem_wvalid = (state_q == c_st_wb_data);
    assign o_mem_wdata  = wb_block_q[int'(cnt_q)*BUS_WIDTH +: BUS_WIDTH];
    assign o_mem_wlast  = (state_q == c_st_wb_data) && w_last_beat;
    assign o_mem_bready = (state_q == c_st_wb_resp);
    assign o_mem_rready = (state_q == c_st_rd_data);
    assign o_block_we   = (state_q == c_st_done);
    assign o_block      = block_q;

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_mem_bridge
//  Purpose  : Self-checking bench for dcache_mem_bridge. A transaction-level
//             model (handshake counters, expected beat sequences, expected
//             line) plus a memory responder checks the DUT every cycle;
//             directed tests add hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_mem_bridge;

    localparam int SW = 512;
    localparam int BW = 64;
    localparam int AW = 64;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          i_arstn;
    logic          i_miss, i_dirty;
    logic [AW-1:0] i_addr, i_addr_wb;
    logic [SW-1:0] i_wb_block;
    logic [SW-1:0] o_block;
    logic          o_block_we, o_busy;
    logic          o_mem_avalid, i_mem_aready;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_we;
    logic          o_mem_wvalid, i_mem_wready;
    logic [BW-1:0] o_mem_wdata;
    logic          o_mem_wlast;
    logic          i_mem_bvalid, o_mem_bready;
    logic          i_mem_rvalid, o_mem_rready;
    logic [BW-1:0] i_mem_rdata;
    logic          i_mem_rlast;
    logic          o_err;

    dcache_mem_bridge #(.SET_WIDTH(SW), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .i_clk(clk), .i_arstn(i_arstn),
        .i_miss(i_miss), .i_dirty(i_dirty), .i_addr(i_addr), .i_addr_wb(i_addr_wb),
        .i_wb_block(i_wb_block), .o_block(o_block), .o_block_we(o_block_we), .o_busy(o_busy),
        .o_mem_avalid(o_mem_avalid), .i_mem_aready(i_mem_aready), .o_mem_addr(o_mem_addr),
        .o_mem_we(o_mem_we), .o_mem_wvalid(o_mem_wvalid), .i_mem_wready(i_mem_wready),
        .o_mem_wdata(o_mem_wdata), .o_mem_wlast(o_mem_wlast), .i_mem_bvalid(i_mem_bvalid),
        .o_mem_bready(o_mem_bready), .i_mem_rvalid(i_mem_rvalid), .o_mem_rready(o_mem_rready),
        .i_mem_rdata(i_mem_rdata), .i_mem_rlast(i_mem_rlast), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
        return {a[AW-1:6], 6'b0};
    endfunction

    function automatic logic [SW-1:0] seq_line(input logic [BW-1:0] base);
        logic [SW-1:0] b;
        for (int k = 0; k < NB; k++) b[k*BW +: BW] = base + BW'(k);
        return b;
    endfunction

    // ---------------- model configuration (set by stimulus) -------------
    logic [SW-1:0] m_rd_blk;
    bit            m_stall;
    int            m_rlast_beat;

    // ---------------- transaction model ---------------------------------
    bit            act, a_dirty, a_stall;
    logic [AW-1:0] a_waddr, a_raddr;
    logic [SW-1:0] a_wblk, a_rblk;
    int            a_rlast;
    bit            aw_done, ar_done, b_done, err_exp;
    int            w_cnt, r_cnt;
    logic [SW-1:0] m_block;
    int            cyc, act_cyc, lat, done_cnt, wlast_cnt;
    logic [AW-1:0] last_rd_addr, last_wr_addr;
    logic [BW-1:0] wlog[$];
    bit            pa_pend, pa_we, pw_pend;
    logic [AW-1:0] pa_addr;
    logic [BW-1:0] pw_data;

    always @(negedge clk) begin : compare_proc
        bit wb_pend, ahs, whs, bhs, rhs;
        cyc++;
        if (!i_arstn) begin
            act = 0; aw_done = 0; ar_done = 0; b_done = 0; w_cnt = 0; r_cnt = 0;
            err_exp = 0; m_block = '0; pa_pend = 0; pw_pend = 0;
            i_mem_aready = 0; i_mem_wready = 0; i_mem_bvalid = 0;
            i_mem_rvalid = 0; i_mem_rlast = 0; i_mem_rdata = '0;
        end else begin
            wb_pend = act && a_dirty && !b_done;
            // ---- compare outputs against the model ----
            chk("busy", o_busy, act);
            chk("err", o_err, err_exp);
            chk("block", o_block, m_block);
            chk("block_we", o_block_we, act && r_cnt == NB);
            if (pa_pend) begin
                chk("avalid_hold", o_mem_avalid, 1'b1);
                chk("addr_hold", o_mem_addr, pa_addr);
                chk("we_hold", o_mem_we, pa_we);
            end
            if (o_mem_avalid) begin
                chk("avalid_legal", act && (wb_pend ? !aw_done : !ar_done), 1'b1);
                chk("mem_we", o_mem_we, wb_pend);
                chk("mem_addr", o_mem_addr, wb_pend ? a_waddr : a_raddr);
            end
            if (pw_pend) begin
                chk("wvalid_hold", o_mem_wvalid, 1'b1);
                chk("wdata_hold", o_mem_wdata, pw_data);
            end
            if (o_mem_wvalid) begin
                chk("wvalid_legal", act && a_dirty && aw_done && w_cnt < NB, 1'b1);
                if (w_cnt < NB) begin
                    chk("wdata", o_mem_wdata, a_wblk[w_cnt*BW +: BW]);
                    chk("wlast", o_mem_wlast, w_cnt == NB-1);
                end
            end
            if (o_mem_bready) chk("bready_legal", act && a_dirty && w_cnt == NB && !b_done, 1'b1);
            if (o_mem_rready) chk("rready_legal", act && ar_done && r_cnt < NB, 1'b1);

            // ---- memory responder: drive inputs for the coming edge ----
            i_mem_aready = a_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            i_mem_wready = a_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            i_mem_bvalid = act && a_dirty && w_cnt == NB && !b_done &&
                           (a_stall ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (act && ar_done && r_cnt < NB && (a_stall ? ($urandom_range(0, 1) == 1) : 1'b1)) begin
                i_mem_rvalid = 1'b1;
                i_mem_rdata  = a_rblk[r_cnt*BW +: BW];
                i_mem_rlast  = (r_cnt == a_rlast);
            end else begin
                i_mem_rvalid = 1'b0;
                i_mem_rlast  = 1'b0;
            end

            // ---- advance the model by the handshakes of the coming edge ----
            ahs = o_mem_avalid && i_mem_aready;
            whs = o_mem_wvalid && i_mem_wready;
            bhs = i_mem_bvalid && o_mem_bready;
            rhs = i_mem_rvalid && o_mem_rready;
            pa_pend = o_mem_avalid && !i_mem_aready; pa_addr = o_mem_addr; pa_we = o_mem_we;
            pw_pend = o_mem_wvalid && !i_mem_wready; pw_data = o_mem_wdata;
            if (ahs && act) begin
                if (wb_pend) begin aw_done = 1; last_wr_addr = o_mem_addr; end
                else begin ar_done = 1; last_rd_addr = o_mem_addr; end
            end
            if (whs && act && w_cnt < NB) begin
                wlog.push_back(o_mem_wdata);
                if (o_mem_wlast) wlast_cnt++;
                w_cnt++;
            end
            if (bhs && act) b_done = 1;
            if (rhs && act && r_cnt < NB) begin
                m_block[r_cnt*BW +: BW] = i_mem_rdata;
`ifdef DCACHE_BRIDGE_RLAST_CHECK_EN
                if (i_mem_rlast != (r_cnt == NB-1)) err_exp = 1;
`endif
                r_cnt++;
            end
            if (o_block_we && act && r_cnt == NB) begin
                chk("refill_line", o_block, a_rblk);
                lat = cyc - act_cyc;
                done_cnt++;
                act = 0;
            end
            if (!act && i_miss && !o_busy) begin
                act = 1; a_dirty = i_dirty; a_waddr = align(i_addr_wb); a_raddr = align(i_addr);
                a_wblk = i_wb_block; a_rblk = m_rd_blk; a_stall = m_stall; a_rlast = m_rlast_beat;
                aw_done = 0; ar_done = 0; b_done = 0; w_cnt = 0; r_cnt = 0; act_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------------------------
    task automatic start_miss(input logic dirty, input logic [AW-1:0] a, input logic [AW-1:0] aw,
                              input logic [SW-1:0] wblk, input logic [SW-1:0] rblk,
                              input bit stall, input int rl);
        @(posedge clk); #2;
        m_rd_blk = rblk; m_stall = stall; m_rlast_beat = rl;
        i_dirty = dirty; i_addr = a; i_addr_wb = aw; i_wb_block = wblk; i_miss = 1'b1;
        @(posedge clk); #2;
        // Scramble the request inputs: the captured copies must be used.
        i_miss = 1'b0; i_addr = '1; i_addr_wb = '1; i_wb_block = '1; i_dirty = ~dirty;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < 400) begin @(posedge clk); n++; end
        if (done_cnt == d0) begin
            vecs++; errs++;
            $display("FAIL timeout: no refill strobe within 400 cycles");
        end
        @(posedge clk); #2;
    endtask

    task automatic wait_rready();
        int n = 0;
        while (!o_mem_rready && n < 200) begin @(negedge clk); n++; end
        if (!o_mem_rready) begin
            vecs++; errs++;
            $display("FAIL timeout: read data phase never reached");
        end
    endtask

    task automatic wait_wvalid();
        int n = 0;
        while (!o_mem_wvalid && n < 200) begin @(negedge clk); n++; end
        if (!o_mem_wvalid) begin
            vecs++; errs++;
            $display("FAIL timeout: write data phase never reached");
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_avalid"}, o_mem_avalid, 1'b0);
        chk({tag, "_wvalid"}, o_mem_wvalid, 1'b0);
        chk({tag, "_bready"}, o_mem_bready, 1'b0);
        chk({tag, "_rready"}, o_mem_rready, 1'b0);
        chk({tag, "_block_we"}, o_block_we, 1'b0);
        chk({tag, "_block"}, o_block, '0);
        chk({tag, "_err"}, o_err, 1'b0);
    endtask

    // ---------------- directed tests -----------------------------------
    initial begin
        logic [SW-1:0] blk0;
        logic          exp_err;
        int            d0;
        blk0 = seq_line(64'h0);
`ifdef DCACHE_BRIDGE_RLAST_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        i_arstn = 1'b0; i_miss = 1'b0; i_dirty = 1'b0; i_addr = '0; i_addr_wb = '0; i_wb_block = '0;
        m_rd_blk = '0; m_stall = 0; m_rlast_beat = NB-1;
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("por");
        #1 i_arstn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: clean miss, zero-wait memory
        start_miss(1'b0, 64'h1234, 64'h0, '0, blk0, 0, NB-1);
        wait_done();
        chk("t1_rd_addr", last_rd_addr, 64'h1200);
        chk("t1_latency", lat, 10);
        chk("t1_block_hi", o_block[511:448], 64'h7);
        chk("t1_block_lo", o_block[127:0], {64'h1, 64'h0});

        // 2: dirty miss, zero-wait memory
        wlog.delete(); wlast_cnt = 0;
        start_miss(1'b1, 64'h5000, 64'h8040, seq_line(64'hA0), seq_line(64'h100), 0, NB-1);
        wait_done();
        chk("t2_wr_addr", last_wr_addr, 64'h8040);
        chk("t2_rd_addr", last_rd_addr, 64'h5000);
        chk("t2_wbeats", wlog.size(), NB);
        if (wlog.size() == NB) begin
            chk("t2_wbeat0", wlog[0], 64'hA0);
            chk("t2_wbeat7", wlog[7], 64'hA7);
        end
        chk("t2_wlast_count", wlast_cnt, 1);
        chk("t2_latency", lat, 20);
        chk("t2_block_hi", o_block[511:448], 64'h107);

        // 3: dirty miss with random stalls on every channel
        wlog.delete(); wlast_cnt = 0;
        start_miss(1'b1, 64'h1234, 64'h77C0, seq_line(64'hB0), blk0, 1, NB-1);
        wait_done();
        chk("t3_block", o_block, blk0);
        chk("t3_wbeats", wlog.size(), NB);
        if (wlog.size() == NB) chk("t3_wbeat7", wlog[7], 64'hB7);
        chk("t3_wr_addr", last_wr_addr, 64'h77C0);

        // 4: second miss while busy is ignored
        d0 = done_cnt;
        start_miss(1'b0, 64'h2010, 64'h0, '0, seq_line(64'hC0), 0, NB-1);
        wait_rready();
        @(posedge clk); #2;
        i_miss = 1'b1; i_dirty = 1'b1; i_addr = 64'h99C0; i_addr_wb = 64'h1111;
        @(posedge clk); #2;
        i_miss = 1'b0;
        wait_done();
        repeat (15) @(posedge clk);
        chk("t4_rd_addr", last_rd_addr, 64'h2000);
        chk("t4_block_lo", o_block[63:0], 64'hC0);
        chk("t4_one_refill", done_cnt - d0, 1);

        // 5: reset in the middle of the write burst, then a fresh miss
        start_miss(1'b1, 64'h3000, 64'h6000, seq_line(64'hD0), seq_line(64'hE0), 1, NB-1);
        wait_wvalid();
        repeat (2) @(posedge clk);
        #3 i_arstn = 1'b0;
        #1 chk_reset_outputs("midrst");
        @(negedge clk); @(negedge clk);
        @(posedge clk); #2 i_arstn = 1'b1;
        start_miss(1'b0, 64'h4000_0080, 64'h0, '0, seq_line(64'hF00), 0, NB-1);
        wait_done();
        chk("t5_rd_addr", last_rd_addr, 64'h4000_0080);
        chk("t5_block_lo", o_block[63:0], 64'hF00);
        chk("t5_latency", lat, 10);

        // 6: rlast on beat 5 (early) and absent on beat 7
        start_miss(1'b0, 64'h1A00, 64'h0, '0, seq_line(64'h50), 0, 5);
        wait_done();
        chk("t6_err", o_err, exp_err);
        chk("t6_block", o_block, seq_line(64'h50));
        start_miss(1'b0, 64'h1A40, 64'h0, '0, blk0, 0, NB-1);
        wait_done();
        chk("t6_err_sticky", o_err, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
